// File: rtl/nabp_bank_ring_control.sv
`timescale 1ns/1ps
// Ring-of-banks controller: fetches angles and orders bank fills up to NUM_BANKS-1 ahead,
// while a KICK/RUN/RELEASE sequencer walks the PEs over each filled bank in ring order.
module nabp_bank_ring_control #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1,
    parameter int ANGLE_W   = 12,
    parameter int LINES     = 16,
    parameter int LINE_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fr_has_next_angle,
    input  logic [ANGLE_W-1:0] fr_angle,
    output logic               fr_next_angle,
    input  logic               fr_next_angle_ack,
    output logic               fill_start,
    output logic [BANK_W-1:0]  fill_bank,
    output logic [ANGLE_W-1:0] fill_angle,
    input  logic               fill_done,
    output logic               pe_kick,
    output logic               pe_en,
    output logic [BANK_W-1:0]  pe_bank,
    output logic [ANGLE_W-1:0] pe_angle,
    output logic [LINE_W-1:0]  pe_line_itr,
    output logic               done
);
    localparam logic [1:0] SLOT_FREE    = 2'd0;
    localparam logic [1:0] SLOT_FILLING = 2'd1;
    localparam logic [1:0] SLOT_READY   = 2'd2;
    localparam logic [1:0] SLOT_BUSY    = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_KICK    = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

    logic [1:0]         slot_state_reg [NUM_BANKS];
    logic [ANGLE_W-1:0] slot_angle_reg [NUM_BANKS];

    logic [BANK_W-1:0]  wr_ptr_reg, rd_ptr_reg, fill_bank_reg, pe_bank_reg;
    logic [ANGLE_W-1:0] fill_angle_reg, pe_angle_reg;
    logic               req_reg, fill_pending_reg, fill_start_reg, done_reg;
    logic [1:0]         state_reg, state_next;
    logic [LINE_W-1:0]  line_reg, line_next;

    logic [NUM_BANKS-1:0] slot_free, slot_ready, ack_hit, done_hit, kick_hit, release_hit;
    logic ack_take, done_take, kick_take, release_take, req_rise, done_next;

    // An ack only counts while a request is up; fill_done only while a fill is outstanding.
    assign ack_take     = req_reg && fr_next_angle_ack;
    assign done_take    = fill_done && fill_pending_reg;
    assign kick_take    = (state_reg == ST_IDLE) && slot_ready[rd_ptr_reg];
    assign release_take = (state_reg == ST_RELEASE);
    assign req_rise     = !req_reg && fr_has_next_angle && slot_free[wr_ptr_reg] && !fill_pending_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_slot
            assign slot_free[gi]   = (slot_state_reg[gi] == SLOT_FREE);
            assign slot_ready[gi]  = (slot_state_reg[gi] == SLOT_READY);
            assign ack_hit[gi]     = ack_take && (wr_ptr_reg == BANK_W'(gi));
            assign done_hit[gi]    = done_take && (fill_bank_reg == BANK_W'(gi));
            assign kick_hit[gi]    = kick_take && (rd_ptr_reg == BANK_W'(gi));
            assign release_hit[gi] = release_take && (rd_ptr_reg == BANK_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                slot_state_reg[i] <= SLOT_FREE;
                slot_angle_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (ack_hit[i]) begin
                    slot_state_reg[i] <= SLOT_FILLING;
                    slot_angle_reg[i] <= fr_angle;
                end else if (done_hit[i]) begin
                    slot_state_reg[i] <= SLOT_READY;
                end else if (kick_hit[i]) begin
                    slot_state_reg[i] <= SLOT_BUSY;
                end else if (release_hit[i]) begin
                    slot_state_reg[i] <= SLOT_FREE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_reg          <= 1'b0;
            fill_pending_reg <= 1'b0;
            fill_start_reg   <= 1'b0;
            fill_bank_reg    <= '0;
            fill_angle_reg   <= '0;
            wr_ptr_reg       <= '0;
        end else begin
            fill_start_reg <= ack_take;
            if (done_take) begin
                fill_pending_reg <= 1'b0;
            end
            if (ack_take) begin
                req_reg          <= 1'b0;
                fill_pending_reg <= 1'b1;
                fill_bank_reg    <= wr_ptr_reg;
                fill_angle_reg   <= fr_angle;
                wr_ptr_reg       <= (wr_ptr_reg == LAST_BANK) ? '0 : wr_ptr_reg + BANK_W'(1);
            end else if (req_rise) begin
                req_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        case (state_reg)
            ST_IDLE: begin
                if (kick_take) begin
                    state_next = ST_KICK;
                end
            end
            ST_KICK: begin
                state_next = ST_RUN;
                line_next  = '0;
            end
            ST_RUN: begin
                if (line_reg == LAST_LINE) begin
                    state_next = ST_RELEASE;
                    line_next  = '0;
                end else begin
                    line_next = line_reg + LINE_W'(1);
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                line_next  = '0;
            end
        endcase
    end

    assign done_next = !fr_has_next_angle && (&slot_free) && !req_reg &&
                       !fill_pending_reg && (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            line_reg     <= '0;
            rd_ptr_reg   <= '0;
            pe_bank_reg  <= '0;
            pe_angle_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            line_reg  <= line_next;
            done_reg  <= done_next;
            // Latched on entry to KICK so both are already valid in the kick cycle.
            if (kick_take) begin
                pe_bank_reg  <= rd_ptr_reg;
                pe_angle_reg <= slot_angle_reg[rd_ptr_reg];
            end
            if (release_take) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_BANK) ? '0 : rd_ptr_reg + BANK_W'(1);
            end
        end
    end

    assign fr_next_angle = req_reg;
    assign fill_start    = fill_start_reg;
    assign fill_bank     = fill_bank_reg;
    assign fill_angle    = fill_angle_reg;
    assign pe_kick       = (state_reg == ST_KICK);
    assign pe_en         = (state_reg == ST_RUN);
    assign pe_bank       = pe_bank_reg;
    assign pe_angle      = pe_angle_reg;
    assign pe_line_itr   = line_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_nabp_bank_ring_control.sv
`timescale 1ns/1ps
// Directed bench: a two-bank/16-line instance and a four-bank/4-line instance driven
// through fetch, fill, pass, reset-abort and completion sequences.
module tb_nabp_bank_ring_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // two-bank instance
    logic        rst2_n, has2, ack2, fd2;
    logic [11:0] ang2;
    logic        req2, fs2, kick2, en2, done2;
    logic [0:0]  fbank2, pbank2;
    logic [11:0] fang2, pang2;
    logic [3:0]  itr2;

    // four-bank instance
    logic        rst4_n, has4, ack4, fd4;
    logic [11:0] ang4;
    logic        req4, fs4, kick4, en4, done4;
    logic [1:0]  fbank4, pbank4;
    logic [11:0] fang4, pang4;
    logic [1:0]  itr4;

    nabp_bank_ring_control #(.NUM_BANKS(2), .BANK_W(1), .ANGLE_W(12), .LINES(16), .LINE_W(4)) dut2 (
        .clk(clk), .reset_n(rst2_n), .fr_has_next_angle(has2), .fr_angle(ang2),
        .fr_next_angle(req2), .fr_next_angle_ack(ack2), .fill_start(fs2), .fill_bank(fbank2),
        .fill_angle(fang2), .fill_done(fd2), .pe_kick(kick2), .pe_en(en2), .pe_bank(pbank2),
        .pe_angle(pang2), .pe_line_itr(itr2), .done(done2)
    );

    nabp_bank_ring_control #(.NUM_BANKS(4), .BANK_W(2), .ANGLE_W(12), .LINES(4), .LINE_W(2)) dut4 (
        .clk(clk), .reset_n(rst4_n), .fr_has_next_angle(has4), .fr_angle(ang4),
        .fr_next_angle(req4), .fr_next_angle_ack(ack4), .fill_start(fs4), .fill_bank(fbank4),
        .fill_angle(fang4), .fill_done(fd4), .pe_kick(kick4), .pe_en(en4), .pe_bank(pbank4),
        .pe_angle(pang4), .pe_line_itr(itr4), .done(done4)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset2(input logic has, input logic [11:0] ang);
        rst2_n = 1'b0; has2 = has; ang2 = ang; ack2 = 1'b0; fd2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst2_n = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [63:0] outs2;
        return {29'd0, req2, fs2, fbank2, fang2, kick2, en2, pbank2, pang2, itr2, done2};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int fcyc2 [3] = '{3, 12, 31};
        int kcyc2 [3] = '{10, 29, 48};
        int bank2 [3] = '{0, 1, 0};
        int fcyc4 [8] = '{2, 5, 8, 11, 14, 19, 26, 33};
        int rcyc4 [8] = '{1, 4, 7, 10, 13, 18, 25, 32};
        int nfill, nkick, nreq, run_cnt, req_age, fd_cnt, next_ang, done_cyc, ahead, max_ahead;
        logic ack_prev, req_prev;

        rst4_n = 1'b0; has4 = 1'b0; ang4 = '0; ack4 = 1'b0; fd4 = 1'b0;

        // ---- A: no angles from reset ----
        reset2(1'b0, 12'h000);
        chk("A reset outputs", outs2(), 64'd0);
        step;
        chk("A done one cycle after reset", done2, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            chk("A no request", req2, 1'b0);
            if (c == 3) has2 = 1'b1;
            step;
        end
        chk("A done falls", done2, 1'b0);
        chk("A request after has_next", req2, 1'b1);

        // ---- B: three angles through two banks ----
        reset2(1'b1, 12'h000);
        chk("B reset outputs", outs2(), 64'd0);
        nfill = 0; nkick = 0; run_cnt = 0; req_age = 0; fd_cnt = 0;
        next_ang = 0; done_cyc = -1; ack_prev = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (fs2) begin
                if (nfill < 3) begin
                    chk("B fill cycle", cyc, fcyc2[nfill]);
                    chk("B fill bank", fbank2, bank2[nfill]);
                    chk("B fill angle", fang2, nfill);
                end
                nfill++;
            end
            if (kick2) begin
                if (nkick < 3) begin
                    chk("B kick cycle", cyc, kcyc2[nkick]);
                    chk("B pe bank", pbank2, bank2[nkick]);
                    chk("B pe angle", pang2, nkick);
                end
                if (nkick > 0) chk("B run length", run_cnt, 16);
                run_cnt = 0;
                nkick++;
            end
            if (en2) begin
                chk("B line itr", itr2, run_cnt);
                run_cnt++;
            end else begin
                chk("B line itr idle", itr2, 0);
            end
            if (done2 && done_cyc < 0) done_cyc = cyc;
            if (ack_prev) next_ang++;
            has2 = (next_ang < 3);
            ang2 = 12'(next_ang);
            ack_prev = 1'b0;
            if (req2) begin
                ack2 = (req_age >= 1);
                ack_prev = ack2;
                req_age++;
            end else begin
                ack2 = 1'b0;
                req_age = 0;
            end
            fd2 = 1'b0;
            if (fd_cnt != 0) begin
                fd_cnt--;
                if (fd_cnt == 0) fd2 = 1'b1;
            end
            if (fs2) fd_cnt = 5;
            step;
        end
        chk("B fills total", nfill, 3);
        chk("B kicks total", nkick, 3);
        chk("B last run length", run_cnt, 16);
        chk("B done cycle", done_cyc, 67);

        // ---- C: spurious ack/fill_done, withheld ack, reset mid-run ----
        reset2(1'b1, 12'h5A5);
        ack2 = 1'b1;
        step;
        ack2 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("C request held", req2, 1'b1);
            chk("C no fill before ack", fs2, 1'b0);
            chk("C no kick before fill", kick2, 1'b0);
            fd2 = (c == 2);
            step;
        end
        chk("C request at ack", req2, 1'b1);
        ack2 = 1'b1;
        step;
        ack2 = 1'b0;
        chk("C fill_start after ack", fs2, 1'b1);
        chk("C fill bank", fbank2, 1'b0);
        chk("C fill angle", fang2, 12'h5A5);
        chk("C request fell", req2, 1'b0);
        step;
        fd2 = 1'b1;
        step;
        fd2 = 1'b0;
        chk("C no kick yet", kick2, 1'b0);
        step;
        chk("C kick 2 after fill_done", kick2, 1'b1);
        chk("C kick bank", pbank2, 1'b0);
        chk("C kick angle", pang2, 12'h5A5);
        repeat (8) step;
        chk("C itr before reset", itr2, 4'd7);
        chk("C en before reset", en2, 1'b1);
        #2 rst2_n = 1'b0;
        #1 chk("C outputs in reset", outs2(), 64'd0);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        cyc = 0;
        ang2 = 12'h03C;
        step;
        chk("C refetch request", req2, 1'b1);
        ack2 = 1'b1;
        step;
        ack2 = 1'b0;
        chk("C refetch fill_start", fs2, 1'b1);
        chk("C refetch bank 0", fbank2, 1'b0);
        chk("C refetch angle", fang2, 12'h03C);
        #2 rst2_n = 1'b0;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        cyc = 0;
        fd2 = 1'b1;
        step;
        fd2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("C stale fill_done ignored", {kick2, en2}, 2'b00);
            step;
        end

        // ---- D: four banks, instant fill_done, PE-bound ----
        rst2_n = 1'b0;
        has4 = 1'b1; ang4 = '0; ack4 = 1'b0; fd4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst4_n = 1'b1;
        cyc = 0;
        nfill = 0; nkick = 0; nreq = 0; next_ang = 0; done_cyc = -1;
        max_ahead = 0; ack_prev = 1'b0; req_prev = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (req4 && !req_prev) begin
                if (nreq < 8) chk("D request cycle", cyc, rcyc4[nreq]);
                nreq++;
            end
            req_prev = req4;
            if (fs4) begin
                if (nfill < 8) begin
                    chk("D fill cycle", cyc, fcyc4[nfill]);
                    chk("D fill bank", fbank4, nfill % 4);
                    chk("D fill angle", fang4, nfill);
                end
                nfill++;
            end
            if (kick4) begin
                chk("D kick cycle", cyc, 4 + 7 * nkick);
                chk("D pe bank", pbank4, nkick % 4);
                chk("D pe angle", pang4, nkick);
                nkick++;
            end
            ahead = nfill - nkick;
            if (ahead > max_ahead) max_ahead = ahead;
            if (done4 && done_cyc < 0) done_cyc = cyc;
            if (ack_prev) next_ang++;
            has4 = (next_ang < 8);
            ang4 = 12'(next_ang);
            ack4 = req4;
            ack_prev = ack4;
            fd4 = fs4;
            step;
        end
        chk("D requests total", nreq, 8);
        chk("D fills total", nfill, 8);
        chk("D kicks total", nkick, 8);
        chk("D fill lead", max_ahead, 3);
        chk("D done cycle", done_cyc, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
